// File: rtl/spi_target.sv
// spi_target: SPI target (slave) with a single transmit holding register.
// sclk, ss and mosi are resynchronised into clk and edge-detected. Words are
// WIDTH bits long and sent and received MSB first. Back-to-back words are
// supported inside one ss window.
// Optional feature: define SPI_TARGET_UNDERRUN_EN to add the tx_underrun
// output. It pulses for one clk at each word start that has no data to send.
module spi_target #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
`ifdef SPI_TARGET_UNDERRUN_EN
    output logic             tx_underrun,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // synchronizers and edge-detect registers
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   ss_dly_q, ss_dly_d;

    // After reset, ss must be observed high before a transfer is accepted.
    logic [1:0]             fill_q, fill_d;
    logic                   armed_q, armed_d;

    state_t                 state_q, state_d;
    logic                   cpol_l_q, cpol_l_d;
    logic                   cpha_l_q, cpha_l_d;
    logic                   first_q, first_d;   // skip the first leading edge (cpha=1)
    logic                   pend_q, pend_d;     // word wrapped; next shift edge starts a word
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0]       rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0]       hold_q, hold_d;
    logic                   tx_ready_q, tx_ready_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   miso_q, miso_d;
    logic                   busy_q, busy_d;
`ifdef SPI_TARGET_UNDERRUN_EN
    logic                   underrun_q, underrun_d;
`endif

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic lead_edge, trail_edge, smp_edge, sft_edge;
    logic start, shift;

    // Next-state logic for the synchronizers, the FSM and the datapath.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        ss_s        = ss_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_dly_d  = sclk_s;
        ss_dly_d    = ss_s;

        sclk_rise   = sclk_s & ~sclk_dly_q;
        sclk_fall   = ~sclk_s & sclk_dly_q;
        ss_fall     = ~ss_s & ss_dly_q;
        ss_rise     = ss_s & ~ss_dly_q;
        lead_edge   = cpol_l_q ? sclk_fall : sclk_rise;
        trail_edge  = cpol_l_q ? sclk_rise : sclk_fall;
        smp_edge    = cpha_l_q ? trail_edge : lead_edge;
        sft_edge    = cpha_l_q ? lead_edge : trail_edge;

        // The sync chain holds reset values until it has been refilled from the pins.
        fill_d      = (fill_q != 2'(SYNC_STAGES)) ? fill_q + 2'd1 : fill_q;
        armed_d     = armed_q | ((fill_q == 2'(SYNC_STAGES)) & ss_s);

        state_d     = state_q;
        cpol_l_d    = cpol_l_q;
        cpha_l_d    = cpha_l_q;
        first_d     = first_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        hold_d      = hold_q;
        tx_ready_d  = tx_ready_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
`ifdef SPI_TARGET_UNDERRUN_EN
        underrun_d  = 1'b0;
`endif
        start       = 1'b0;
        shift       = 1'b0;

        case (state_q)
            IDLE: begin
                if (armed_q && ss_fall) begin
                    state_d  = ACTIVE;
                    cpol_l_d = cpol;
                    cpha_l_d = cpha;
                    cnt_d    = '0;
                    first_d  = cpha;
                    pend_d   = 1'b0;
                    start    = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    // Abort: drop any partial word, keep rx_data and holding.
                    state_d = IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    first_d = 1'b0;
                end else begin
                    if (smp_edge) begin
                        rx_sr_d = {rx_sr_q[WIDTH-2:0], mosi_s};
                        if (cnt_q == CW'(WIDTH-1)) begin
                            cnt_d      = '0;
                            rx_data_d  = {rx_sr_q[WIDTH-2:0], mosi_s};
                            rx_valid_d = 1'b1;
                            pend_d     = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    if (sft_edge) begin
                        if (pend_q) begin
                            start  = 1'b1;
                            pend_d = 1'b0;
                        end else if (first_q) begin
                            first_d = 1'b0;
                        end else begin
                            shift = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Word start takes the old holding content; a same-cycle write lands after.
        if (start) begin
            tx_sr_d    = tx_ready_q ? '0 : hold_q;
            tx_ready_d = 1'b1;
`ifdef SPI_TARGET_UNDERRUN_EN
            underrun_d = tx_ready_q;
`endif
        end else if (shift) begin
            tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
        end

        if (tx_valid && tx_ready_q) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end

        miso_d = (state_d == ACTIVE) & tx_sr_d[WIDTH-1];
        busy_d = (state_d == ACTIVE);
    end

    // State registers, all reset asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            ss_dly_q    <= 1'b1;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cpol_l_q    <= 1'b0;
            cpha_l_q    <= 1'b0;
            first_q     <= 1'b0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            hold_q      <= '0;
            tx_ready_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SPI_TARGET_UNDERRUN_EN
            underrun_q  <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            ss_dly_q    <= ss_dly_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cpol_l_q    <= cpol_l_d;
            cpha_l_q    <= cpha_l_d;
            first_q     <= first_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            hold_q      <= hold_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
`ifdef SPI_TARGET_UNDERRUN_EN
            underrun_q  <= underrun_d;
`endif
        end
    end

    assign miso     = miso_q;
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
`ifdef SPI_TARGET_UNDERRUN_EN
    assign tx_underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Testbench for spi_target: a behavioural SPI master plus a transfer-level model.
module tb_spi_target;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int HALF = 5;   // sclk half period in clk cycles

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
    logic         miso;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
`ifdef SPI_TARGET_UNDERRUN_EN
    logic         tx_underrun;
    int           urn = 0;
`endif

    spi_target #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss(ss),
        .mosi(mosi), .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef SPI_TARGET_UNDERRUN_EN
        .tx_underrun(tx_underrun),
`endif
        .busy(busy));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] rxq[$];

    // Record every received word; a pulse longer than one clk shows as an extra word.
    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_data);
`ifdef SPI_TARGET_UNDERRUN_EN
        if (tx_underrun) urn++;
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-transfer stimulus and results: mosi words, holding supply, observed miso words.
    logic [W-1:0] m_out[4];
    logic [W-1:0] val[4];
    bit           sup[4];
    logic [W-1:0] m_in[4];

    task automatic half(input bit do_wr, input logic [W-1:0] d);
        @(negedge clk);
        if (do_wr) begin
            tx_valid = 1'b1;
            tx_data  = d;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (HALF-2) @(negedge clk);
    endtask

    task automatic wr(input logic [W-1:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Master: clocks total_bits bits across nw words in one ss window.
    task automatic xfer(input bit pol, input bit pha, input int nw, input int total_bits);
        int w, i;
        bit dw;
        for (int k = 0; k < 4; k++) m_in[k] = '0;
        rxq.delete();
        cpol = pol; cpha = pha; sclk = pol;
        repeat (4) @(negedge clk);
        if (sup[0]) wr(val[0]);
        repeat (3) @(negedge clk);
        ss = 1'b0;
        if (!pha) mosi = m_out[0][W-1];
        repeat (8) @(negedge clk);
        for (int b = 0; b < total_bits; b++) begin
            w  = b / W;
            i  = W - 1 - (b % W);
            dw = ((b % W) == 3) && (w + 1 < nw) && sup[w+1];
            if ((b % W) == 3) begin
                chk("tx_ready_mid_word", tx_ready, 1);
                chk("busy_mid_word", busy, 1);
            end
            if (pha) begin
                sclk = ~pol;
                mosi = m_out[w][i];
                half(dw, val[(w+1) % 4]);
                m_in[w][i] = miso;
                sclk = pol;
                half(1'b0, '0);
            end else begin
                m_in[w][i] = miso;
                sclk = ~pol;
                half(dw, val[(w+1) % 4]);
                sclk = pol;
                if (b + 1 < total_bits) mosi = m_out[(b+1)/W][W-1-((b+1)%W)];
                half(1'b0, '0);
            end
        end
        ss   = 1'b1;
        mosi = 1'b0;
        repeat (SYNC+2) @(negedge clk);
        chk("busy_after_ss_rise", busy, 0);
        repeat (8) @(negedge clk);
    endtask

    // Model: the target returns each supplied word (or zeros) and delivers every mosi word.
    task automatic check_xfer(input string tag, input int nw);
        chk({tag, "_rx_count"}, rxq.size(), nw);
        for (int k = 0; k < nw; k++) begin
            if (k < rxq.size()) chk({tag, "_rx_word"}, rxq[k], m_out[k]);
            chk({tag, "_miso_word"}, m_in[k], sup[k] ? val[k] : '0);
        end
    endtask

    typedef struct {
        string        name;
        bit           pol, pha, wr_en;
        logic [W-1:0] hold, master_tx, exp_rx, exp_miso;
        int           exp_urn;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [W-1:0] prev;
        tbl[0] = '{"mode00",   1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, -1};
        tbl[1] = '{"mode11",   1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, -1};
        tbl[2] = '{"mode10",   1'b1, 1'b0, 1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81, -1};
        tbl[3] = '{"mode01",   1'b0, 1'b1, 1'b1, 8'h5C, 8'hC6, 8'hC6, 8'h5C, -1};
        tbl[4] = '{"underrun", 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00, 1};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // single-word vectors
        foreach (tbl[v]) begin
            m_out[0] = tbl[v].master_tx;
            sup[0]   = tbl[v].wr_en;
            val[0]   = tbl[v].hold;
`ifdef SPI_TARGET_UNDERRUN_EN
            urn = 0;
`endif
            xfer(tbl[v].pol, tbl[v].pha, 1, W);
            chk({tbl[v].name, "_rx_count"}, rxq.size(), 1);
            chk({tbl[v].name, "_rx_data"}, rx_data, tbl[v].exp_rx);
            chk({tbl[v].name, "_miso"}, m_in[0], tbl[v].exp_miso);
`ifdef SPI_TARGET_UNDERRUN_EN
            if (tbl[v].exp_urn >= 0) chk({tbl[v].name, "_underruns"}, urn, tbl[v].exp_urn);
`endif
        end

        // two back-to-back words, second supplied mid-transfer
        m_out[0] = 8'hF0; m_out[1] = 8'h0F;
        sup[0] = 1; val[0] = 8'h11; sup[1] = 1; val[1] = 8'h22;
        xfer(1'b0, 1'b1, 2, 2*W);
        check_xfer("b2b", 2);

        // abort after 5 bits, then a full word
        prev = rx_data;
        m_out[0] = 8'h99; sup[0] = 1; val[0] = 8'h42;
        xfer(1'b0, 1'b0, 1, 5);
        chk("abort_rx_count", rxq.size(), 0);
        chk("abort_rx_data_kept", rx_data, prev);
        m_out[0] = 8'h5A; sup[0] = 1; val[0] = 8'h6B;
        xfer(1'b0, 1'b0, 1, W);
        check_xfer("post_abort", 1);
        chk("post_abort_rx_data", rx_data, 8'h5A);

        // reset asserted at bit 4 of a transfer
        rxq.delete();
        cpol = 0; cpha = 0; sclk = 0;
        wr(8'hA5);
        repeat (3) @(negedge clk);
        ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            mosi = b[0];
            sclk = 1'b1; repeat (HALF) @(negedge clk);
            sclk = 1'b0; repeat (HALF) @(negedge clk);
        end
        sclk = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_miso", miso, 0);
        chk("arst_rx_data", rx_data, 0);
        chk("arst_rx_valid", rx_valid, 0);
        chk("arst_tx_ready", tx_ready, 1);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < 2*W; b++) begin
            sclk = 1'b0; repeat (HALF) @(negedge clk);
            sclk = 1'b1; repeat (HALF) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (HALF) @(negedge clk);
        chk("post_rst_ignored_busy", busy, 0);
        chk("post_rst_ignored_rx", rxq.size(), 0);
        ss = 1'b1;
        repeat (10) @(negedge clk);
        m_out[0] = 8'h96; sup[0] = 1; val[0] = 8'h3C;
        xfer(1'b0, 1'b0, 1, W);
        check_xfer("post_rst", 1);

        // randomized transfers against the model
        for (int t = 0; t < 20; t++) begin
            int nw;
            bit p, h;
            nw = $urandom_range(1, 3);
            p  = 1'($urandom_range(0, 1));
            h  = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                m_out[k] = W'($urandom);
                val[k]   = W'($urandom);
                sup[k]   = 1'($urandom_range(0, 1));
            end
            xfer(p, h, nw, nw*W);
            check_xfer("rand", nw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #5000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
